// File: rtl/mvau_weight_seq_if.sv
// Weight stream bundle between the MVAU weight sequencer and its PE lane.
// Carries the weight word, fold markers and the valid/ready handshake.
interface mvau_weight_seq_if #(
    parameter int DW = 2
);
    logic [DW-1:0] wgt_tdata;
    logic          wgt_sf_last;
    logic          wgt_last;
    logic          wgt_tvalid;
    logic          wgt_tready;

    modport master (
        output wgt_tdata,
        output wgt_sf_last,
        output wgt_last,
        output wgt_tvalid,
        input  wgt_tready
    );

    modport slave (
        input  wgt_tdata,
        input  wgt_sf_last,
        input  wgt_last,
        input  wgt_tvalid,
        output wgt_tready
    );
endinterface

// File: rtl/mvau_weight_seq.sv
// Weight-memory sequencer for one MVAU PE lane: linear address sweeps,
// a 2-stage tag pipeline matching the memory latency, and a 4-deep skid FIFO.
module mvau_weight_seq #(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int SF           = 2,
    parameter int NF           = 2,
    parameter int WMEM_ADDR_BW = 4,
    parameter int REP_BW       = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic [REP_BW-1:0]       num_reps,
    output logic                    busy,
    output logic                    done,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    input  logic [SIMD*TW-1:0]      wmem_in,
    mvau_weight_seq_if.master       wgt
);
    localparam int DW    = SIMD * TW;
    localparam int SF_BW = (SF > 1) ? $clog2(SF) : 1;
    localparam int NF_BW = (NF > 1) ? $clog2(NF) : 1;

    localparam logic [SF_BW-1:0] SF_MAX = SF_BW'(SF - 1);
    localparam logic [NF_BW-1:0] NF_MAX = NF_BW'(NF - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SF_BW-1:0]  sf_cnt;
    logic [SF_BW-1:0]  sf_cur;
    logic [SF_BW-1:0]  sf_nxt;
    logic [NF_BW-1:0]  nf_cnt;
    logic [NF_BW-1:0]  nf_cur;
    logic [NF_BW-1:0]  nf_nxt;
    logic [REP_BW-1:0] rep_cnt;
    logic [REP_BW-1:0] rep_cur;
    logic [REP_BW-1:0] rep_nxt;

    logic [WMEM_ADDR_BW-1:0] addr_cur;

    logic accept;
    logic issue;
    logic load_cnt;
    logic room;
    logic is_sf_last;
    logic is_last;
    logic final_issue;
    logic push;
    logic pop;

    logic a_vld;
    logic a_sf_last;
    logic a_last;
    logic m_vld;
    logic m_sf_last;
    logic m_last;

    logic [2:0]    cnt;
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [DW+1:0] fifo_mem [4];

    assign busy   = (state != IDLE) | done;
    assign accept = start & ~busy;
    assign pop    = wgt.wgt_tvalid & wgt.wgt_tready;
    assign push   = m_vld;

    // Words in flight plus queued words must fit the FIFO after this pop.
    assign room = (4'(cnt) + 4'(a_vld) + 4'(m_vld)) < (4'd4 + 4'(pop));

    assign wgt.wgt_tvalid = (cnt != 3'd0);
    assign {wgt.wgt_tdata, wgt.wgt_sf_last, wgt.wgt_last} = fifo_mem[rd_ptr];

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        load_cnt  = 1'b0;
        sf_cur    = sf_cnt;
        nf_cur    = nf_cnt;
        rep_cur   = rep_cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    load_cnt = 1'b1;
                    sf_cur   = '0;
                    nf_cur   = '0;
                    rep_cur  = num_reps;
                    if (num_reps == '0) begin
                        state_nxt = FINISH;
                    end else begin
                        state_nxt = RUN;
                        issue     = room;
                    end
                end
            end
            RUN: begin
                issue = room;
            end
            DRAIN: begin
                if (!a_vld && !m_vld &&
                    (cnt == 3'd0 || (cnt == 3'd1 && pop))) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        is_sf_last  = (sf_cur == SF_MAX);
        is_last     = is_sf_last & (nf_cur == NF_MAX);
        final_issue = issue & is_last & (rep_cur == REP_BW'(1));
        if (final_issue) begin
            state_nxt = DRAIN;
        end

        addr_cur = WMEM_ADDR_BW'(int'(nf_cur) * SF + int'(sf_cur));

        sf_nxt  = sf_cur;
        nf_nxt  = nf_cur;
        rep_nxt = rep_cur;
        if (issue) begin
            if (is_sf_last) begin
                sf_nxt = '0;
                if (nf_cur == NF_MAX) begin
                    nf_nxt  = '0;
                    rep_nxt = rep_cur - 1'b1;
                end else begin
                    nf_nxt = nf_cur + 1'b1;
                end
            end else begin
                sf_nxt = sf_cur + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == FINISH);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sf_cnt    <= '0;
            nf_cnt    <= '0;
            rep_cnt   <= '0;
            wmem_addr <= '0;
        end else begin
            if (load_cnt || issue) begin
                sf_cnt  <= sf_nxt;
                nf_cnt  <= nf_nxt;
                rep_cnt <= rep_nxt;
            end
            if (issue) begin
                wmem_addr <= addr_cur;
            end
        end
    end

    // Tags track each issued address through the address and memory stages.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            a_vld     <= 1'b0;
            a_sf_last <= 1'b0;
            a_last    <= 1'b0;
            m_vld     <= 1'b0;
            m_sf_last <= 1'b0;
            m_last    <= 1'b0;
        end else begin
            a_vld     <= issue;
            a_sf_last <= issue & is_sf_last;
            a_last    <= issue & is_last;
            m_vld     <= a_vld;
            m_sf_last <= a_sf_last;
            m_last    <= a_last;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {wmem_in, m_sf_last, m_last};
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_mvau_weight_seq.sv
// Scoreboard bench for mvau_weight_seq: directed jobs push expected words,
// a negedge monitor pops and compares every handshaken word.
module tb_mvau_weight_seq;
    localparam int SIMD = 4;
    localparam int TW   = 2;
    localparam int SF   = 2;
    localparam int NF   = 2;
    localparam int AW   = 4;
    localparam int RB   = 16;
    localparam int DW   = SIMD * TW;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sfl;
        logic          l;
    } word_t;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          start;
    logic [RB-1:0] num_reps;
    logic          busy;
    logic          done;
    logic [AW-1:0] wmem_addr;
    logic [DW-1:0] wmem_in;

    mvau_weight_seq_if #(.DW(DW)) wgt ();

    mvau_weight_seq #(
        .SIMD(SIMD), .TW(TW), .SF(SF), .NF(NF),
        .WMEM_ADDR_BW(AW), .REP_BW(RB)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .start(start),
        .num_reps(num_reps),
        .busy(busy),
        .done(done),
        .wmem_addr(wmem_addr),
        .wmem_in(wmem_in),
        .wgt(wgt)
    );

    always #5 aclk = ~aclk;

    logic [DW-1:0] mem [16];
    always @(posedge aclk) wmem_in <= mem[wmem_addr];

    logic [DW-1:0] exp_d [4];
    logic [3:0]    exp_sfl;
    logic [3:0]    exp_l;

    int    vectors = 0;
    int    miscompares = 0;
    word_t q[$];
    int    pops = 0;
    int    lasts = 0;
    bit    stalled = 0;
    word_t held;
    int    rdy_mode = 0;
    int    stall_left = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge aclk) begin
        #1;
        if (stall_left > 0) begin
            wgt.wgt_tready = 1'b0;
            stall_left--;
        end else if (rdy_mode == 1) begin
            wgt.wgt_tready = 1'($urandom_range(0, 1));
        end else begin
            wgt.wgt_tready = 1'b1;
        end
    end

    always @(negedge aclk) begin
        word_t cur;
        word_t e;
        cur = '{wgt.wgt_tdata, wgt.wgt_sf_last, wgt.wgt_last};
        if (!aresetn) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                check("stall_stable", {wgt.wgt_tvalid, cur}, {1'b1, held});
            end
            if (wgt.wgt_tvalid && wgt.wgt_tready) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_word: got %0h expected none", cur);
                end else begin
                    e = q.pop_front();
                    check("word", cur, e);
                    pops++;
                    if (wgt.wgt_last) lasts++;
                end
                stalled = 0;
            end else if (wgt.wgt_tvalid) begin
                stalled = 1;
                held    = cur;
            end else begin
                stalled = 0;
            end
        end
    end

    task automatic push_exp(input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int a = 0; a < 4; a++) begin
                q.push_back('{exp_d[a], exp_sfl[a], exp_l[a]});
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_addr"}, 64'(wmem_addr), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_tvalid"}, 64'(wgt.wgt_tvalid), 64'd0);
        check({tag, "_tdata"}, 64'(wgt.wgt_tdata), 64'd0);
        check({tag, "_sflast"}, 64'(wgt.wgt_sf_last), 64'd0);
        check({tag, "_last"}, 64'(wgt.wgt_last), 64'd0);
    endtask

    task automatic run_job(input int reps, input bit extra, input int probe_i,
                           output int first_v, output int done_lat,
                           output int busy_cyc, output int ndone,
                           output logic [AW-1:0] addr0,
                           output logic [AW-1:0] probe_addr,
                           output logic probe_v);
        first_v    = -1;
        done_lat   = -1;
        busy_cyc   = 0;
        ndone      = 0;
        addr0      = '1;
        probe_addr = '1;
        probe_v    = 1'b0;
        push_exp(reps);
        @(posedge aclk);
        #1;
        start    = 1'b1;
        num_reps = RB'(reps);
        @(posedge aclk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge aclk);
            if (i == 1) addr0 = wmem_addr;
            if (i == probe_i) begin
                probe_addr = wmem_addr;
                probe_v    = wgt.wgt_tvalid;
            end
            if (extra && i == 3) start = 1'b1;
            if (i == 4) start = 1'b0;
            if (busy) busy_cyc++;
            if (wgt.wgt_tvalid && first_v < 0) first_v = i - 1;
            if (done) begin
                ndone++;
                if (done_lat < 0) done_lat = i - 1;
            end
            if (done_lat >= 0 && i >= done_lat + 6) break;
        end
    endtask

    initial begin
        int fv, dl, bc, nd, p0;
        logic [AW-1:0] a0, pa;
        logic pv;

        for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
        exp_d[0] = 8'hA0;
        exp_d[1] = 8'hA1;
        exp_d[2] = 8'hA2;
        exp_d[3] = 8'hA3;
        exp_sfl  = 4'b1010;
        exp_l    = 4'b1000;

        aresetn  = 1'b0;
        start    = 1'b0;
        num_reps = '0;
        repeat (3) @(posedge aclk);
        #1;
        check_reset("rst");
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);

        run_job(1, 0, 0, fv, dl, bc, nd, a0, pa, pv);
        check("basic_addr0", 64'(a0), 64'd0);
        check("basic_first_valid", 64'(fv), 64'd2);
        check("basic_done_lat", 64'(dl), 64'd7);
        check("basic_busy_cyc", 64'(bc), 64'd8);
        check("basic_ndone", 64'(nd), 64'd1);
        check("basic_drained", 64'(q.size()), 64'd0);

        lasts = 0;
        run_job(3, 0, 0, fv, dl, bc, nd, a0, pa, pv);
        check("rep_done_lat", 64'(dl), 64'd15);
        check("rep_busy_cyc", 64'(bc), 64'd16);
        check("rep_ndone", 64'(nd), 64'd1);
        check("rep_lasts", 64'(lasts), 64'd3);
        check("rep_drained", 64'(q.size()), 64'd0);

        run_job(0, 0, 0, fv, dl, bc, nd, a0, pa, pv);
        check("zero_first_valid", 64'(fv), 64'(-1));
        check("zero_done_lat", 64'(dl), 64'd1);
        check("zero_busy_cyc", 64'(bc), 64'd2);
        check("zero_ndone", 64'(nd), 64'd1);

        stall_left = 14;
        rdy_mode   = 1;
        run_job(2, 0, 10, fv, dl, bc, nd, a0, pa, pv);
        rdy_mode = 0;
        check("bp_frozen_addr", 64'(pa), 64'd3);
        check("bp_valid_held", 64'(pv), 64'd1);
        check("bp_ndone", 64'(nd), 64'd1);
        check("bp_drained", 64'(q.size()), 64'd0);

        p0 = pops;
        run_job(1, 1, 0, fv, dl, bc, nd, a0, pa, pv);
        check("sb_words", 64'(pops - p0), 64'd4);
        check("sb_ndone", 64'(nd), 64'd1);
        check("sb_done_lat", 64'(dl), 64'd7);
        check("sb_drained", 64'(q.size()), 64'd0);

        p0 = pops;
        push_exp(2);
        @(posedge aclk);
        #1;
        start    = 1'b1;
        num_reps = RB'(2);
        @(posedge aclk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 100 && pops < p0 + 2; i++) @(negedge aclk);
        check("pre_reset_words", 64'(pops - p0), 64'd2);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        check_reset("midrst");
        q.delete();
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;

        run_job(1, 0, 0, fv, dl, bc, nd, a0, pa, pv);
        check("restart_addr0", 64'(a0), 64'd0);
        check("restart_first_valid", 64'(fv), 64'd2);
        check("restart_done_lat", 64'(dl), 64'd7);
        check("restart_drained", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
